// File: rtl/fib_sequencer.sv
// Control FSM that sequences the register-file + ALU datapath to fill r0..r(NUM_TERMS-1)
// with the Fibonacci series, one write per cycle, and tracks the last written register.
module fib_sequencer #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned NUM_TERMS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic [ADDR_W-1:0] ra_addr,
  output logic [ADDR_W-1:0] rb_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic [1:0]        alu_op,
  output logic              imm_sel,
  output logic              imm_val,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] disp_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT0 = 3'd1,
    S_INIT1 = 3'd2,
    S_CALC  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0]        OP_ADD    = 2'b00;
  localparam logic [1:0]        OP_PASS_B = 2'b11;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_TERMS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  // State, index and display-address registers; disp_addr follows every committed write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      disp_addr <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (wr_en) disp_addr <= wr_addr;
    end
  end

  // Next-state and Moore output decode; hold stalls every busy state and masks the write.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ra_addr = '0;
    rb_addr = '0;
    wr_addr = '0;
    wr_en   = 1'b0;
    alu_op  = OP_ADD;
    imm_sel = 1'b0;
    imm_val = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT0;
          idx_d   = '0;
        end
      end

      S_INIT0: begin
        busy    = 1'b1;
        wr_en   = ~hold;
        imm_sel = 1'b1;
        alu_op  = OP_PASS_B;
        if (!hold) state_d = S_INIT1;
      end

      S_INIT1: begin
        busy    = 1'b1;
        wr_en   = ~hold;
        wr_addr = ADDR_W'(1);
        imm_sel = 1'b1;
        imm_val = 1'b1;
        alu_op  = OP_PASS_B;
        if (!hold) begin
          state_d = S_CALC;
          idx_d   = ADDR_W'(2);
        end
      end

      S_CALC: begin
        busy    = 1'b1;
        wr_en   = ~hold;
        ra_addr = idx_q - ADDR_W'(2);
        rb_addr = idx_q - ADDR_W'(1);
        wr_addr = idx_q;
        if (!hold) begin
          // Final term: idx stays put so DONE keeps showing the last addresses.
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + ADDR_W'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        ra_addr = idx_q - ADDR_W'(2);
        rb_addr = idx_q - ADDR_W'(1);
        wr_addr = idx_q;
        if (start) begin
          state_d = S_INIT0;
          idx_d   = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fib_sequencer.sv
// Directed bench for fib_sequencer: behavioural regfile/ALU models around a 16-term
// and a 3-term instance, checked with immediate assertions.
module tb_fib_sequencer;

  localparam int unsigned ADDR_W = 4;

  logic clk = 1'b0;
  logic reset, start, hold, start3;

  logic [ADDR_W-1:0] ra_addr, rb_addr, wr_addr, disp_addr;
  logic              wr_en, imm_sel, imm_val, busy, done;
  logic [1:0]        alu_op;

  logic [ADDR_W-1:0] ra3, rb3, wa3, disp3;
  logic              we3, isel3, ival3, busy3, done3;
  logic [1:0]        op3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fib_sequencer #(.ADDR_W(ADDR_W), .NUM_TERMS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .wr_addr(wr_addr), .wr_en(wr_en),
    .alu_op(alu_op), .imm_sel(imm_sel), .imm_val(imm_val),
    .busy(busy), .done(done), .disp_addr(disp_addr)
  );

  fib_sequencer #(.ADDR_W(ADDR_W), .NUM_TERMS(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .hold(1'b0),
    .ra_addr(ra3), .rb_addr(rb3), .wr_addr(wa3), .wr_en(we3),
    .alu_op(op3), .imm_sel(isel3), .imm_val(ival3),
    .busy(busy3), .done(done3), .disp_addr(disp3)
  );

  // Behavioural datapath: 16x16 register file plus ALU and immediate mux.
  logic [15:0] rf [16];
  logic [15:0] rf3 [16];
  logic [15:0] wdata, wdata3;
  int          wcount = 0, wcount3 = 0;
  logic [ADDR_W-1:0] last_wa;
  logic [15:0]       last_wd;

  function automatic logic [15:0] alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return b;
    endcase
  endfunction

  always_comb begin
    wdata  = imm_sel ? 16'(imm_val) : alu(alu_op, rf[ra_addr], rf[rb_addr]);
    wdata3 = isel3 ? 16'(ival3) : alu(op3, rf3[ra3], rf3[rb3]);
  end

  always @(posedge clk) begin
    if (wr_en) begin
      rf[wr_addr] <= wdata;
      last_wa     <= wr_addr;
      last_wd     <= wdata;
      wcount      <= wcount + 1;
    end
    if (we3) begin
      rf3[wa3] <= wdata3;
      wcount3  <= wcount3 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles from the current point until done rises, bounded.
  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      step();
      n++;
    end
  endtask

  int n, base;

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0; start3 = 1'b0;
    repeat (2) step();
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_alu_op", 32'(alu_op), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_disp", 32'(disp_addr), 0);
    reset = 1'b0;
    step();

    // Basic 16-term run
    start = 1'b1; base = wcount;
    step();
    start = 1'b0;
    check("init0_busy", 32'(busy), 1);
    check("init0_wr_en", 32'(wr_en), 1);
    check("init0_imm_sel", 32'(imm_sel), 1);
    check("init0_alu_op", 32'(alu_op), 3);
    wait_done(40, n);
    check("run1_latency", 32'(n), 16);
    check("run1_writes", 32'(wcount - base), 16);
    check("run1_r2", 32'(rf[2]), 1);
    check("run1_r7", 32'(rf[7]), 13);
    check("run1_r15", 32'(rf[15]), 610);
    check("run1_disp", 32'(disp_addr), 15);
    check("run1_done_busy", 32'(busy), 0);
    check("run1_done_wr_en", 32'(wr_en), 0);
    check("run1_done_wr_addr", 32'(wr_addr), 15);

    // Restart from DONE
    start = 1'b1; base = wcount;
    step();
    start = 1'b0;
    check("restart_done_drop", 32'(done), 0);
    check("restart_busy", 32'(busy), 1);
    step();
    check("restart_r0_addr", 32'(last_wa), 0);
    check("restart_r0_data", 32'(last_wd), 0);
    check("restart_one_write", 32'(wcount - base), 1);
    wait_done(40, n);
    check("restart_latency", 32'(n), 15);
    check("restart_last_data", 32'(last_wd), 610);

    // hold for 5 cycles at idx=6
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    check("pre_hold_wr_addr", 32'(wr_addr), 6);
    check("pre_hold_wr_en", 32'(wr_en), 1);
    hold = 1'b1;
    #1;
    check("hold_gate_wr_en", 32'(wr_en), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_wr_en", 32'(wr_en), 0);
      check("hold_idx", 32'(wr_addr), 6);
      check("hold_disp", 32'(disp_addr), 5);
    end
    hold = 1'b0;
    step();
    check("resume_addr", 32'(last_wa), 6);
    check("resume_data", 32'(last_wd), 8);
    wait_done(40, n);
    check("hold_latency", 32'(n), 9);

    // start pulse during CALC is ignored
    start = 1'b1; base = wcount;
    step();
    start = 1'b0;
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("midrun_busy", 32'(busy), 1);
    check("midrun_wr_addr", 32'(wr_addr), 5);
    wait_done(40, n);
    check("midrun_latency", 32'(n), 11);
    check("midrun_writes", 32'(wcount - base), 16);
    check("midrun_r7", 32'(rf[7]), 13);
    check("midrun_last_data", 32'(last_wd), 610);

    // Async reset mid-CALC at idx=9, off the clock edge
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check("pre_reset_idx", 32'(wr_addr), 9);
    #2 reset = 1'b1;
    #1;
    check("areset_wr_en", 32'(wr_en), 0);
    check("areset_busy", 32'(busy), 0);
    check("areset_done", 32'(done), 0);
    check("areset_addrs", 32'({ra_addr, rb_addr, wr_addr}), 0);
    check("areset_ctrl", 32'({alu_op, imm_sel, imm_val}), 0);
    check("areset_disp", 32'(disp_addr), 0);
    reset = 1'b0;
    step();
    start = 1'b1; base = wcount;
    step();
    start = 1'b0;
    wait_done(40, n);
    check("post_reset_latency", 32'(n), 16);
    check("post_reset_writes", 32'(wcount - base), 16);
    check("post_reset_last_data", 32'(last_wd), 610);
    check("post_reset_r15", 32'(rf[15]), 610);
    check("post_reset_disp", 32'(disp_addr), 15);

    // NUM_TERMS=3 instance
    start3 = 1'b1; base = wcount3;
    step();
    start3 = 1'b0;
    n = 0;
    while (!done3 && n < 20) begin
      step();
      n++;
    end
    check("n3_latency", 32'(n), 3);
    check("n3_writes", 32'(wcount3 - base), 3);
    check("n3_r0", 32'(rf3[0]), 0);
    check("n3_r1", 32'(rf3[1]), 1);
    check("n3_r2", 32'(rf3[2]), 1);
    check("n3_disp", 32'(disp3), 2);
    check("n3_busy", 32'(busy3), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_sequencer.md
Name: fib_sequencer

Overview:
- Control FSM that sequences the shared register-file + ALU datapath so it fills registers r0..r(NUM_TERMS-1) with the Fibonacci series, one write per cycle.
- Drives register-file read/write addresses, write enable, ALU opcode and immediate-path selection.
- Exports status and a display address so the 7-segment display path can show the most recently written register.
- Sits between the top level (clk, reset, start from a debounced button) and the datapath.

Parameters:
- ADDR_W, 4, register-file address width.
- NUM_TERMS, 16, number of terms to produce. Legal range 3..2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- hold  input  1  pause; freezes the sequence while high.
- ra_addr  output  ADDR_W  register-file read port A address.
- rb_addr  output  ADDR_W  register-file read port B address.
- wr_addr  output  ADDR_W  register-file write address.
- wr_en  output  1  register-file write enable.
- alu_op  output  2  ALU opcode: 00 ADD, 01 SUB, 10 AND, 11 PASS_B. This block emits only 00 and 11.
- imm_sel  output  1  1 = write-data mux takes imm_val, 0 = takes ALU result.
- imm_val  output  1  immediate bit, zero-extended by the datapath.
- busy  output  1  high in INIT0, INIT1 and CALC.
- done  output  1  level; high in DONE.
- disp_addr  output  ADDR_W  address of the last register written; feeds the display read port.

Behaviour:
- States: IDLE, INIT0, INIT1, CALC, DONE. 3-bit state register, plus an ADDR_W-bit index register idx.
- Reset (async, any state):
  - state=IDLE, idx=0, disp_addr=0.
  - All outputs 0: wr_en, busy, done, imm_sel, imm_val, alu_op, ra_addr, rb_addr, wr_addr.
- IDLE: outputs as at reset. start=1 -> INIT0 next edge.
- INIT0:
  - Drives wr_en=1, wr_addr=0, imm_sel=1, imm_val=0, alu_op=PASS_B.
  - -> INIT1.
- INIT1:
  - Drives wr_en=1, wr_addr=1, imm_sel=1, imm_val=1, alu_op=PASS_B.
  - -> CALC, idx<=2.
- CALC:
  - Drives ra_addr=idx-2, rb_addr=idx-1, wr_addr=idx, alu_op=ADD, imm_sel=0, wr_en=1.
  - Each cycle idx<=idx+1.
  - When idx==NUM_TERMS-1 the write still occurs, then -> DONE.
- DONE: done=1, busy=0, wr_en=0, addresses hold their last values. start=1 -> INIT0 (restart; idx reload).
- Output decode and timing:
  - All outputs are Moore decodes of state/idx. Exception: wr_en is additionally gated combinationally by ~hold.
  - Write timing: the datapath commits on the same rising edge that advances the state.
- disp_addr:
  - Updates to wr_addr on every edge where wr_en=1.
  - Holds otherwise; in DONE it equals NUM_TERMS-1.
- hold=1 in INIT0, INIT1 or CALC:
  - wr_en=0 and state/idx/disp_addr frozen.
  - The sequence resumes exactly where it paused the cycle hold falls.
  - hold has no effect in IDLE or DONE.
- start while busy=1 is ignored; a run is never restarted mid-way.
- start and hold high together in IDLE/DONE: the transition to INIT0 occurs; INIT0 then stalls until hold falls.
- Latency:
  - start sampled at edge k -> first write at edge k+1.
  - With hold=0, done=1 after edge k+NUM_TERMS.
- Address arithmetic is ADDR_W bits, unsigned. idx never wraps because NUM_TERMS<=2**ADDR_W.
- Data width and overflow are the datapath's concern; this block carries no data.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
- Reset, then start pulse with NUM_TERMS=16 and a behavioural 16x16 regfile/ALU model:
  - Required: exactly 16 writes.
  - Required: r2=1, r7=13, r15=610.
  - Required: done rises 16 cycles after start is sampled; disp_addr=15.
- hold=1 for 5 cycles while idx=6 in CALC:
  - Required: wr_en=0 and idx=6 throughout.
  - Required: resumes writing r6=8; done is delayed by exactly 5 cycles.
- start re-pulsed during CALC: no restart, busy stays 1, final register values unchanged.
- Async reset asserted mid-CALC (idx=9) for 1 ns, off a clock edge:
  - Required: all outputs go to 0 immediately and state=IDLE.
  - Required: a following start gives a complete correct run, r15=610.
- start in DONE: restart at INIT0, r0 rewritten with 0, done drops the cycle after start is sampled.
- NUM_TERMS=3: writes r0=0, r1=1, r2=1, then DONE; done is high 3 cycles after start.
